// File: rtl/chan_mask_xmit.sv
// chan_mask_xmit
//   Holds a shadow bitmap of per-channel enables and streams it as a
//   tlast-terminated burst of WORD_W-bit words to the channelizer's
//   channel-select AXI-Stream input.
//
// Ports
//   clk, sync_reset       clock, asynchronous active-high reset
//   fft_size              active channel count (power of two), sampled when a
//                         commit is accepted; out-of-range values mean MAX_CHANS
//   cfg_valid/chan/en     single-channel enable write; cfg_ready accepts it
//   clear_all             pulse: zero the whole bitmap
//   commit                pulse: transmit words 0..fft_size/WORD_W-1
//   busy                  high outside IDLE or while a clear/commit is latched
//   m_axis_*              select stream (word k bit b = channel WORD_W*k+b)
module chan_mask_xmit #(
  parameter int MAX_CHANS = 2048,
  parameter int WORD_W    = 32
) (
  input  logic                         clk,
  input  logic                         sync_reset,
  input  logic [$clog2(MAX_CHANS):0]   fft_size,
  input  logic                         cfg_valid,
  input  logic [$clog2(MAX_CHANS)-1:0] cfg_chan,
  input  logic                         cfg_en,
  output logic                         cfg_ready,
  input  logic                         clear_all,
  input  logic                         commit,
  output logic                         busy,
  output logic                         m_axis_tvalid,
  output logic [WORD_W-1:0]            m_axis_tdata,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready
);

  localparam int CH_W   = $clog2(MAX_CHANS);
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int DEPTH  = MAX_CHANS / WORD_W;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_RMW_RD,
    S_RMW_WR,
    S_SEND
  } state_t;

  state_t state, state_nx;

  // Shadow RAM, one-cycle synchronous read, no reset
  logic [WORD_W-1:0] mem [DEPTH];
  logic              mem_we, rd_en;
  logic [ADDR_W-1:0] mem_wa, rd_addr;
  logic [WORD_W-1:0] mem_wd, ram_q;

  logic              pend_clr, pend_com;
  logic              clr_req, com_req, take_clr, take_com;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] cfg_word;
  logic [BIT_W-1:0]  cfg_bit;
  logic              cfg_en_q;
  logic [CNT_W-1:0]  n_words, rd_idx, fft_words, n_new;
  logic              fft_ok;
  logic              q_valid, q_last, load_out, rd_more;

  // A cfg write in IDLE wins the cycle; a simultaneous clear/commit stays
  // latched and is serviced once the read-modify-write finishes.
  assign clr_req  = pend_clr | clear_all;
  assign com_req  = pend_com | commit;
  assign take_clr = (state == S_IDLE) && !cfg_valid && clr_req;
  assign take_com = (state == S_IDLE) && !cfg_valid && !clr_req && com_req;

  always_comb begin
    fft_words = fft_size[CH_W:BIT_W];
    fft_ok    = (fft_size[BIT_W-1:0] == '0) && (fft_words != '0) &&
                ((fft_words & (fft_words - CNT_W'(1))) == '0);
    n_new     = fft_ok ? fft_words : CNT_W'(DEPTH);
  end

  // ram_q only changes on rd_en, so while the output register is stalled it
  // holds the prefetched next word and acts as a second pipeline stage.
  assign load_out = (state == S_SEND) && q_valid && (!m_axis_tvalid || m_axis_tready);
  assign rd_more  = (state == S_SEND) && (rd_idx < n_words) && (!q_valid || load_out);

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    if (rd_en)  ram_q <= mem[rd_addr];
  end

  // State register
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) state <= S_CLEAR;
    else            state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_CLEAR:  if (clr_addr == '1) state_nx = S_IDLE;
      S_IDLE: begin
        if (cfg_valid)    state_nx = S_RMW_RD;
        else if (clr_req) state_nx = S_CLEAR;
        else if (com_req) state_nx = S_SEND;
      end
      S_RMW_RD: state_nx = S_RMW_WR;
      S_RMW_WR: state_nx = S_IDLE;
      S_SEND:   if (m_axis_tvalid && m_axis_tready && m_axis_tlast) state_nx = S_IDLE;
      default:  state_nx = S_CLEAR;
    endcase
  end

  // Output / RAM control logic
  always_comb begin
    cfg_ready = (state == S_IDLE);
    busy      = (state != S_IDLE) || pend_clr || pend_com;
    mem_we    = 1'b0;
    mem_wa    = clr_addr;
    mem_wd    = '0;
    rd_en     = 1'b0;
    rd_addr   = rd_idx[ADDR_W-1:0];
    case (state)
      S_CLEAR: mem_we = 1'b1;
      S_IDLE: begin
        // Word 0 is fetched on the accepting cycle to meet the 2-cycle latency
        rd_en   = take_com;
        rd_addr = '0;
      end
      S_RMW_RD: begin
        rd_en   = 1'b1;
        rd_addr = cfg_word;
      end
      S_RMW_WR: begin
        mem_we          = 1'b1;
        mem_wa          = cfg_word;
        mem_wd          = ram_q;
        mem_wd[cfg_bit] = cfg_en_q;
      end
      S_SEND:  rd_en = rd_more;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      clr_addr      <= '0;
      pend_clr      <= 1'b0;
      pend_com      <= 1'b0;
      cfg_word      <= '0;
      cfg_bit       <= '0;
      cfg_en_q      <= 1'b0;
      n_words       <= '0;
      rd_idx        <= '0;
      q_valid       <= 1'b0;
      q_last        <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      clr_addr <= (state == S_CLEAR) ? clr_addr + ADDR_W'(1) : '0;
      pend_clr <= take_clr ? 1'b0 : clr_req;
      pend_com <= take_com ? 1'b0 : com_req;

      if (state == S_IDLE && cfg_valid) begin
        cfg_word <= cfg_chan[CH_W-1:BIT_W];
        cfg_bit  <= cfg_chan[BIT_W-1:0];
        cfg_en_q <= cfg_en;
      end

      if (take_com) begin
        n_words <= n_new;
        rd_idx  <= CNT_W'(1);
        q_valid <= 1'b1;
        q_last  <= (n_new == CNT_W'(1));
      end else if (rd_more) begin
        rd_idx  <= rd_idx + CNT_W'(1);
        q_valid <= 1'b1;
        q_last  <= (rd_idx == n_words - CNT_W'(1));
      end else if (load_out) begin
        q_valid <= 1'b0;
      end

      if (load_out) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= ram_q;
        m_axis_tlast  <= q_last;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chan_mask_xmit.sv
// tb_chan_mask_xmit
//   Self-checking bench for chan_mask_xmit. A flat 2048-bit bitmap is the
//   reference; each burst is compared against slices of it.
module tb_chan_mask_xmit;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic [11:0] fft_size;
  logic        cfg_valid;
  logic [10:0] cfg_chan;
  logic        cfg_en;
  logic        cfg_ready;
  logic        clear_all;
  logic        commit;
  logic        busy;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  always #5 clk = ~clk;

  chan_mask_xmit #(.MAX_CHANS(2048), .WORD_W(32)) dut (
    .clk           (clk),
    .sync_reset    (sync_reset),
    .fft_size      (fft_size),
    .cfg_valid     (cfg_valid),
    .cfg_chan      (cfg_chan),
    .cfg_en        (cfg_en),
    .cfg_ready     (cfg_ready),
    .clear_all     (clear_all),
    .commit        (commit),
    .busy          (busy),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: 1-high/3-low, 2: random
  logic [2047:0] bm;           // reference bitmap
  logic [31:0] rx_data[$];
  logic        rx_last[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_words(input int fft);
    for (int p = 5; p <= 11; p++)
      if (fft == (1 << p)) return fft / 32;
    return 64;
  endfunction

  // One clock: choose tready, log a handshake, then verify stall stability.
  task automatic step();
    logic        hold;
    logic [32:0] hv;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = (cyc % 4 == 0);
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    if (m_axis_tvalid && m_axis_tready) begin
      rx_data.push_back(m_axis_tdata);
      rx_last.push_back(m_axis_tlast);
    end
    hold = m_axis_tvalid && !m_axis_tready;
    hv   = {m_axis_tlast, m_axis_tdata};
    @(posedge clk);
    #1;
    cyc++;
    if (hold && !sync_reset)
      check("hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, hv});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      step();
      n++;
    end
    if (busy) check("idle_timeout", busy, 0);
  endtask

  task automatic measure_clear(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check(tag, n, 64);
  endtask

  task automatic cfg_write(input int ch, input bit en);
    wait_idle();
    cfg_chan  = ch[10:0];
    cfg_en    = en;
    cfg_valid = 1'b1;
    check("cfg_rdy", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    check("cfg_stall1", cfg_ready, 0);
    step();
    check("cfg_stall2", cfg_ready, 0);
    step();
    check("cfg_back", cfg_ready, 1);
    bm[ch] = en;
  endtask

  // Collects until a tlast word (bounded), then compares to the model.
  task automatic collect(input int exp_n, input string tag, input int pulse_at);
    int n = 0;
    bit done = 0;
    while (!done && n < 2000) begin
      commit = (pulse_at >= 0) &&
               (rx_data.size() == pulse_at || rx_data.size() == pulse_at + 2);
      step();
      n++;
      if (rx_last.size() > 0 && rx_last[rx_last.size()-1]) done = 1;
    end
    commit = 1'b0;
    if (!done) check({tag, "_timeout"}, done, 1);
    check({tag, "_len"}, rx_data.size(), exp_n);
    for (int i = 0; i < rx_data.size() && i < exp_n; i++) begin
      check({tag, "_dat"}, rx_data[i], bm[i*32 +: 32]);
      check({tag, "_lst"}, rx_last[i], (i == exp_n - 1));
    end
  endtask

  task automatic do_commit(input int fft, input string tag);
    wait_idle();
    fft_size = fft[11:0];
    rx_data.delete();
    rx_last.delete();
    commit = 1'b1;
    step();
    commit = 1'b0;
    check({tag, "_lat0"}, m_axis_tvalid, 0);
    step();
    check({tag, "_lat1"}, m_axis_tvalid, 1);
    collect(exp_words(fft), tag, -1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int lasts;
    int fft;
    sync_reset = 1'b1;
    fft_size   = 12'd2048;
    cfg_valid  = 1'b0;
    cfg_chan   = '0;
    cfg_en     = 1'b0;
    clear_all  = 1'b0;
    commit     = 1'b0;
    m_axis_tready = 1'b1;
    bm = '0;
    repeat (3) step();
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    sync_reset = 1'b0;
    measure_clear("init_clear_cycles");

    do_commit(2048, "zero");

    cfg_write(0, 1);
    cfg_write(31, 1);
    cfg_write(32, 1);
    cfg_write(2047, 1);
    do_commit(2048, "corner");
    if (rx_data.size() == 64) begin
      check("corner_w0", rx_data[0], 32'h8000_0001);
      check("corner_w1", rx_data[1], 32'h0000_0001);
      check("corner_w63", rx_data[63], 32'h8000_0000);
    end

    cfg_write(600, 1);
    do_commit(512, "fft512");
    do_commit(2048, "ch600");
    if (rx_data.size() == 64) check("ch600_w18", rx_data[18], 32'h0100_0000);
    do_commit(32, "fft32");

    rdy_mode = 1;
    do_commit(2048, "stall");
    rdy_mode = 0;

    // Reset in the middle of a burst
    wait_idle();
    fft_size = 12'd2048;
    rx_data.delete();
    rx_last.delete();
    commit = 1'b1;
    step();
    commit = 1'b0;
    n = 0;
    while (rx_data.size() < 20 && n < 200) begin
      step();
      n++;
    end
    check("rst_mid_words", rx_data.size(), 20);
    sync_reset = 1'b1;
    #1;
    check("rst_mid_tvalid", m_axis_tvalid, 0);
    lasts = 0;
    foreach (rx_last[i]) if (rx_last[i]) lasts++;
    check("rst_mid_no_tlast", lasts, 0);
    step();
    step();
    sync_reset = 1'b0;
    bm = '0;
    measure_clear("rst_clear_cycles");
    do_commit(2048, "post_rst");

    // clear_all and commit together
    cfg_write(5, 1);
    cfg_write(1000, 1);
    wait_idle();
    rx_data.delete();
    rx_last.delete();
    clear_all = 1'b1;
    commit    = 1'b1;
    step();
    clear_all = 1'b0;
    commit    = 1'b0;
    bm = '0;
    collect(64, "clr_com", -1);

    // commit pulsed twice mid-burst gives exactly one more burst
    cfg_write(77, 1);
    wait_idle();
    rx_data.delete();
    rx_last.delete();
    commit = 1'b1;
    step();
    commit = 1'b0;
    collect(64, "mid_a", 10);
    rx_data.delete();
    rx_last.delete();
    collect(64, "mid_b", -1);
    rx_data.delete();
    rx_last.delete();
    repeat (20) step();
    check("mid_no_extra", rx_data.size(), 0);

    // cfg write and commit in the same cycle
    wait_idle();
    rx_data.delete();
    rx_last.delete();
    cfg_chan  = 11'd1500;
    cfg_en    = 1'b1;
    cfg_valid = 1'b1;
    commit    = 1'b1;
    step();
    cfg_valid = 1'b0;
    commit    = 1'b0;
    bm[1500] = 1'b1;
    collect(64, "cfg_com", -1);

    // cfg write and clear_all in the same cycle
    wait_idle();
    cfg_chan  = 11'd900;
    cfg_en    = 1'b1;
    cfg_valid = 1'b1;
    clear_all = 1'b1;
    step();
    cfg_valid = 1'b0;
    clear_all = 1'b0;
    bm[900] = 1'b1;
    bm = '0;
    do_commit(2048, "cfg_clr");

    // Randomized traffic
    for (int i = 0; i < 40; i++) cfg_write($urandom_range(0, 2047), 1'b1);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: cfg_write($urandom_range(0, 2047), 1'($urandom_range(0, 1)));
        6: begin
          wait_idle();
          clear_all = 1'b1;
          step();
          clear_all = 1'b0;
          bm = '0;
        end
        default: begin
          case ($urandom_range(0, 3))
            0:       fft = 2048;
            1:       fft = 1 << $urandom_range(5, 11);
            2:       fft = $urandom_range(0, 4095);
            default: fft = 1 << $urandom_range(0, 4);
          endcase
          rdy_mode = $urandom_range(0, 2);
          do_commit(fft, "rand");
          rdy_mode = 0;
        end
      endcase
    end
    do_commit(2048, "rand_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
